// File: rtl/bidir_tx_sched.sv
// Weighted round-robin, packet-atomic merge of three AXI-stream TX FIFOs into one stream.
// A grant is held until tlast is accepted; the IDLE cycle between packets is where arbitration happens.
module bidir_tx_sched #(
  parameter int DW = 32,
  parameter int KW = DW / 8,
  parameter int UW = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      cfg_en,
  input  logic [11:0]     cfg_weight,
  input  logic [3*DW-1:0] s_tdata,
  input  logic [3*KW-1:0] s_tkeep,
  input  logic [3*UW-1:0] s_tuser,
  input  logic [2:0]      s_tlast,
  input  logic [2:0]      s_tvalid,
  output logic [2:0]      s_tready,
  output logic [DW-1:0]   m_tdata,
  output logic [KW-1:0]   m_tkeep,
  output logic [UW-1:0]   m_tuser,
  output logic            m_tlast,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [1:0]      cur_port,
  output logic            busy,
  output logic [3*CW-1:0] pkt_cnt
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_n;
  logic [1:0]    g, g_n;
  logic [1:0]    ptr, ptr_n;
  logic [3:0]    rem, rem_n;
  logic [CW-1:0] cnt [3];

  logic [2:0]    elig;
  logic          found;
  logic [1:0]    c;
  logic [1:0]    c_next;
  logic [3:0]    w;
  logic [3:0]    rem_new;
  logic          done;
  int            idx;
  int            gi;

  // First eligible port searching from ptr, plus the credit it would be left with.
  always_comb begin
    elig  = s_tvalid & cfg_en;
    found = 1'b0;
    c     = ptr;
    idx   = 0;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(ptr) + k) % 3;
      if (!found && elig[idx]) begin
        found = 1'b1;
        c     = idx[1:0];
      end
    end
    case (c)
      2'd0:    w = cfg_weight[3:0];
      2'd1:    w = cfg_weight[7:4];
      default: w = cfg_weight[11:8];
    endcase
    if (c == ptr && rem != 4'd0) rem_new = rem - 4'd1;
    else if (w == 4'd0)          rem_new = 4'd0;
    else                         rem_new = w - 4'd1;
    c_next = (c == 2'd2) ? 2'd0 : c + 2'd1;
  end

  always_comb begin
    state_n = state;
    g_n     = g;
    ptr_n   = ptr;
    rem_n   = rem;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = XFER;
          g_n     = c;
          rem_n   = rem_new;
          ptr_n   = (rem_new == 4'd0) ? c_next : c;
        end
      end
      XFER: begin
        if (s_tvalid[g] && m_tready && s_tlast[g]) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      g     <= 2'd0;
      ptr   <= 2'd0;
      rem   <= 4'd0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
      ptr   <= ptr_n;
      rem   <= rem_n;
      if (done) cnt[g] <= cnt[g] + 1'b1;
    end
  end

  // Valid/ready: a beat moves when s_tvalid[g] and m_tready are both high in XFER;
  // the granted port sees m_tready directly, every other port sees ready low.
  always_comb begin
    s_tready = 3'b000;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tuser  = '0;
    m_tlast  = 1'b0;
    m_tvalid = 1'b0;
    gi       = int'(g);
    if (state == XFER) begin
      m_tdata     = s_tdata[gi*DW +: DW];
      m_tkeep     = s_tkeep[gi*KW +: KW];
      m_tuser     = s_tuser[gi*UW +: UW];
      m_tlast     = s_tlast[g];
      m_tvalid    = s_tvalid[g];
      s_tready[g] = m_tready;
    end
  end

  assign cur_port = (state == XFER) ? g : 2'd3;
  assign busy     = (state == XFER);

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    assign pkt_cnt[i*CW +: CW] = cnt[i];
  end

endmodule

// File: tb/tb_bidir_tx_sched.sv
// Bench for bidir_tx_sched: random packets per port, expected merged stream built from the
// weighted round-robin order (each enabled port takes max(weight,1) packets per round).
module tb_bidir_tx_sched;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 8;
  localparam int CW = 16;
  localparam int EW = 2 + 1 + UW + KW + DW;

  typedef struct packed {
    logic          first;
    logic          last;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk;
  logic            rst;
  logic [2:0]      cfg_en;
  logic [11:0]     cfg_weight;
  logic [3*DW-1:0] s_tdata;
  logic [3*KW-1:0] s_tkeep;
  logic [3*UW-1:0] s_tuser;
  logic [2:0]      s_tlast;
  logic [2:0]      s_tvalid;
  logic [2:0]      s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [UW-1:0]   m_tuser;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic [1:0]      cur_port;
  logic            busy;
  logic [3*CW-1:0] pkt_cnt;

  bidir_tx_sched #(.DW(DW), .KW(KW), .UW(UW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_weight(cfg_weight),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .cur_port(cur_port), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  beat_t         src_q [3][$];
  logic [EW-1:0] exp_q[$];
  int            exp_cnt [3];
  int            checks;
  int            errors;
  bit            run;
  bit            bubbles;
  bit            rdy_rand;
  logic [2:0]    viol;
  int            cyc;
  bit            in_pkt;
  bit            have_end;
  int            last_end;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_cur_port", 64'(cur_port), 64'd3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // driver tasks
  task automatic gen_pkt(input int p, input int maxlen, input bit expect_it);
    int    len;
    beat_t b;
    len = $urandom_range(1, maxlen);
    for (int k = 0; k < len; k++) begin
      b.first = (k == 0);
      b.last  = (k == len - 1);
      b.user  = UW'($urandom);
      b.keep  = KW'($urandom);
      b.data  = $urandom;
      src_q[p].push_back(b);
      if (expect_it) exp_q.push_back({2'(p), b.last, b.user, b.keep, b.data});
    end
  endtask

  initial begin : driver
    logic [2:0] hs;
    beat_t      b;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      if (run) begin
        for (int i = 0; i < 3; i++) begin
          if (hs[i]) begin
            b = src_q[i].pop_front();
            s_tvalid[i] = 1'b0;
          end
          if (src_q[i].size() > 0) begin
            b = src_q[i][0];
            s_tdata[i*DW +: DW] = b.data;
            s_tkeep[i*KW +: KW] = b.keep;
            s_tuser[i*UW +: UW] = b.user;
            s_tlast[i]          = b.last;
            if (!s_tvalid[i])
              s_tvalid[i] = b.first || !bubbles || ($urandom_range(0, 3) != 0);
          end else begin
            s_tvalid[i] = 1'b0;
          end
        end
        m_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    forever begin
      @(negedge clk);
      cyc++;
      if (run && !rst) begin
        viol = viol | (s_tready & ~cfg_en);
        if (m_tvalid && !in_pkt) begin
          in_pkt = 1'b1;
          if (have_end) check("gap", 64'(cyc - last_end), 64'd2);
        end
        if (m_tvalid && m_tready) begin
          a = {cur_port, m_tlast, m_tuser, m_tkeep, m_tdata};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat actual=%h required=none", a);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(a), 64'(e));
          end
          if (m_tlast) begin
            in_pkt   = 1'b0;
            have_end = 1'b1;
            last_end = cyc;
          end
        end
      end
    end
  end

  task automatic run_phase(input logic [2:0] en, input logic [11:0] wt, input int rounds,
                           input int maxlen, input bit bub, input bit rrand);
    int weff [3];
    int budget;
    cfg_en     = en;
    cfg_weight = wt;
    bubbles    = bub;
    rdy_rand   = rrand;
    do_reset();
    viol     = 3'b000;
    in_pkt   = 1'b0;
    have_end = 1'b0;
    for (int p = 0; p < 3; p++) begin
      exp_cnt[p] = 0;
      weff[p]    = (wt[4*p +: 4] == 4'd0) ? 1 : int'(wt[4*p +: 4]);
    end
    for (int r = 0; r < rounds; r++)
      for (int p = 0; p < 3; p++)
        if (en[p])
          for (int k = 0; k < weff[p]; k++) begin
            gen_pkt(p, maxlen, 1'b1);
            exp_cnt[p]++;
          end
    for (int p = 0; p < 3; p++)
      if (!en[p]) begin
        gen_pkt(p, maxlen, 1'b0);
        gen_pkt(p, maxlen, 1'b0);
      end
    @(negedge clk);
    run = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d_beats_left required=0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    for (int p = 0; p < 3; p++)
      check("pkt_cnt", 64'(pkt_cnt[p*CW +: CW]), 64'(exp_cnt[p] % 65536));
    check("disabled_ready", 64'(viol), 64'd0);
    run      = 1'b0;
    s_tvalid = 3'b000;
    m_tready = 1'b0;
    for (int p = 0; p < 3; p++) src_q[p].delete();
    exp_q.delete();
  endtask

  task automatic reset_mid_pkt();
    cfg_en     = 3'b111;
    cfg_weight = 12'h111;
    s_tvalid   = 3'b000;
    m_tready   = 1'b1;
    do_reset();
    s_tdata[2*DW +: DW] = 32'hA000_0000;
    s_tlast  = 3'b000;
    s_tvalid = 3'b100;
    @(posedge clk);
    #1;
    check("mid_grant", 64'(cur_port), 64'd2);
    check("mid_beat1", 64'(m_tdata), 64'hA000_0000);
    @(posedge clk);
    #1 s_tdata[2*DW +: DW] = 32'hA000_0001;
    @(negedge clk);
    check("mid_beat2", 64'(m_tdata), 64'hA000_0001);
    rst = 1'b1;
    #1;
    check("rst_mid_s_tready", 64'(s_tready), 64'd0);
    check("rst_mid_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_mid_cur_port", 64'(cur_port), 64'd3);
    for (int i = 0; i < 3; i++) begin
      s_tdata[i*DW +: DW] = 32'hB000_0000 + i;
      s_tlast[i]          = 1'b1;
    end
    s_tvalid = 3'b111;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_grant", 64'(cur_port), 64'd0);
    check("post_rst_data", 64'(m_tdata), 64'hB000_0000);
    check("post_rst_cnt", 64'(pkt_cnt), 64'd0);
    s_tvalid = 3'b000;
    m_tready = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    run        = 1'b0;
    cfg_en     = 3'b000;
    cfg_weight = 12'h000;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tuser    = '0;
    s_tlast    = '0;
    s_tvalid   = '0;
    m_tready   = 1'b0;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    viol       = 3'b000;
    run_phase(3'b111, 12'h111, 2, 1, 1'b0, 1'b0);
    run_phase(3'b111, 12'h112, 3, 1, 1'b0, 1'b0);
    run_phase(3'b111, 12'h111, 3, 4, 1'b1, 1'b1);
    run_phase(3'b101, 12'h111, 3, 3, 1'b1, 1'b1);
    run_phase(3'b111, 12'h000, 3, 2, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++)
      run_phase(3'($urandom_range(1, 7)),
                {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                2, 4, 1'b1, 1'b1);
    reset_mid_pkt();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bidir_tx_sched.md
Name: bidir_tx_sched

Overview:
Weighted round-robin, packet-atomic scheduler that merges the three TX FIFO AXI-stream outputs into the single TX stream feeding the bidir block.
- Sits between txfifo0/1/2 and the bidir TX path.
- Per-port enables and weights are static configuration driven from the CPU AXI-lite register space.
- Exports per-port packet counters and grant status for readback.

Parameters:
- DW, 32, stream tdata width in bits.
- KW, DW/8, tkeep width.
- UW, 8, tuser width.
- CW, 16, width of each per-port packet counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_en  in  3  per-port enable; bit i gates port i.
- cfg_weight  in  12  4-bit weight per port; port i uses bits [4i+3:4i].
- s_tdata  in  3*DW  port i data in slice i.
- s_tkeep  in  3*KW  port i keep.
- s_tuser  in  3*UW  port i user.
- s_tlast  in  3  port i last.
- s_tvalid  in  3  port i valid.
- s_tready  out  3  port i ready.
- m_tdata  out  DW  merged data to bidir.
- m_tkeep  out  KW  merged keep.
- m_tuser  out  UW  merged user.
- m_tlast  out  1  merged last.
- m_tvalid  out  1  merged valid.
- m_tready  in  1  bidir ready.
- cur_port  out  2  granted port; 3 = none.
- busy  out  1  high while a packet is in progress.
- pkt_cnt  out  3*CW  completed packets per port; wraps modulo 2^CW.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, ptr=0, rem=0, pkt_cnt=0, cur_port=3, busy=0.
  - s_tready=0, m_tvalid=0.
  - m_tdata, m_tkeep, m_tuser and m_tlast = 0.
- Two states, IDLE and XFER.
- IDLE:
  - All s_tready=0, m_tvalid=0, and m_* data outputs = 0.
  - Eligible set elig = s_tvalid & cfg_en.
  - If elig != 0, choose the first eligible port c in search order ptr, ptr+1, ptr+2 (mod 3).
  - Register the grant g=c and enter XFER at the next edge.
  - This gives exactly one arbitration bubble cycle before every packet.
- Grant-time credit update (same edge as the grant):
  - Effective weight weff(c) = max(cfg_weight[c], 1); a weight of 0 behaves as 1.
  - If c==ptr and rem!=0, then rem_new=rem-1. Otherwise rem_new=weff(c)-1.
  - rem <= rem_new.
  - ptr <= (rem_new==0) ? (c+1 mod 3) : c.
  - Weight changes take effect only at the next reload.
- XFER:
  - m_tdata/tkeep/tuser/tlast/tvalid mirror port g combinationally; s_tready[g]=m_tready; other ready bits are 0.
  - No registering in the data path; latency is zero cycles while in XFER.
  - Beat handshake = s_tvalid[g] & m_tready.
  - On a handshake with s_tlast[g]=1: pkt_cnt[g]++ (wraps) and return to IDLE at the next edge.
  - Packets are atomic: no other port is granted until tlast is accepted, whatever the stalls or bubbles on s_tvalid[g].
  - Deasserting cfg_en[g] mid-packet does not abort the packet; the port is excluded only from later arbitration.
  - Changes to s_tvalid on non-granted ports have no effect.
- cur_port = g in XFER, 3 in IDLE. busy = (state==XFER).
- A port whose enable is low never sees s_tready=1 outside an already-granted packet.
- Reset asserted mid-packet: the packet is truncated downstream, all handshakes drop in the same cycle, and the first grant after release starts its search at port 0.

Test Plan:
1. Weights 1/1/1, all enabled, each port streams single-beat packets continuously -> grant order 0,1,2,0,1,2; m_tvalid low exactly 1 cycle between packets; after 6 packets pkt_cnt = 2/2/2.
2. Weights 2/1/1, all ports always valid -> packet order 0,0,1,2,0,0,1,2.
3. Port1 sends a 4-beat packet (D0..D3) with m_tready pattern 1,0,1,1,0,1; port0 valid throughout -> m_tdata carries D0..D3 in order with no interleave; cur_port=1 until the D3 handshake; port0 is granted 2 cycles after that handshake (1 cycle to IDLE, 1 bubble).
4. cfg_en=3'b101, port1 valid the whole time, ports 0/2 valid -> s_tready[1] never high; ports 0 and 2 alternate; pkt_cnt[1]=0.
5. cfg_weight all 0 -> behaves identically to scenario 1 (round-robin with weight 1).
6. Assert rst during beat 2 of a 4-beat port2 packet -> s_tready, m_tvalid, busy and m_tdata go 0 in the same cycle; cur_port=3; after release with all ports valid, the first grant is port 0.
